// File: rtl/uart_tx_cfg_if.sv
// uart_tx_cfg_if: handshake, frame-configuration and status bundle for uart_tx_cfg.
// master = byte source (command/response logic or TX FIFO), slave = transmitter.
interface uart_tx_cfg_if #(
  parameter int DATA_BITS = 8
);
  logic                 i_Tx_DV;
  logic [DATA_BITS-1:0] i_Tx_Byte;
  logic [1:0]           i_Parity_Mode;
  logic                 i_Two_Stop;
  logic                 o_Tx_Ready;
  logic                 o_Tx_Active;
  logic                 o_Tx_Serial;
  logic                 o_Tx_Done;

  modport master (
    output i_Tx_DV, i_Tx_Byte, i_Parity_Mode, i_Two_Stop,
    input  o_Tx_Ready, o_Tx_Active, o_Tx_Serial, o_Tx_Done
  );

  modport slave (
    input  i_Tx_DV, i_Tx_Byte, i_Parity_Mode, i_Two_Stop,
    output o_Tx_Ready, o_Tx_Active, o_Tx_Serial, o_Tx_Done
  );
endinterface

// File: rtl/uart_tx_cfg.sv
// uart_tx_cfg: parametrised UART transmitter (5..9 data bits, none/odd/even/mark
// parity, one or two stop bits), one character per ready/valid handshake.
// The sequencer runs one cycle ahead of the registered output stage, so every
// output pin comes straight from a flop and the line is glitch-free.
// Optional feature: define UART_TX_BREAK_EN to add the i_Break input and the
// line-break states.
module uart_tx_cfg #(
  parameter int CLKS_PER_BIT = 208,
  parameter int DATA_BITS    = 8
) (
  input  logic         i_Clock,
  input  logic         i_Rst_n,
`ifdef UART_TX_BREAK_EN
  input  logic         i_Break,
`endif
  uart_tx_cfg_if.slave tx
);

  localparam int BAUD_W = $clog2(CLKS_PER_BIT);
  localparam int IDX_W  = $clog2(DATA_BITS);
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_START    = 3'd1,
    S_DATA     = 3'd2,
    S_PARITY   = 3'd3,
    S_STOP     = 3'd4
`ifdef UART_TX_BREAK_EN
    ,
    S_BREAK    = 3'd5,
    S_BRK_MARK = 3'd6
`endif
  } state_t;

  typedef enum logic [1:0] {
    PAR_NONE = 2'b00,
    PAR_ODD  = 2'b01,
    PAR_EVEN = 2'b10,
    PAR_MARK = 2'b11
  } parity_t;

  // Sequencer state
  state_t              state_q, state_d;
  logic [BAUD_W-1:0]   baud_q, baud_d, baud_next;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic                stop2_q, stop2_d;
  logic                bit_end;

  // Frame registers (captured at acceptance)
  logic [DATA_BITS-1:0] data_q;
  logic                 par_en_q;
  logic                 par_bit_q;
  logic                 two_stop_q;
  logic                 par_calc;

  // Output stage
  logic serial_q, serial_d;
  logic ready_q, ready_d;
  logic active_q;
  logic done_q;
  logic frame_end_q, frame_end;

  // Sequencer events
  logic accept;
  logic brk_go;

  assign bit_end   = (baud_q == BAUD_LAST);
  assign baud_next = bit_end ? '0 : baud_q + BAUD_W'(1);

  // Parity of the character on the bus, ready to be latched with it.
  always_comb begin
    par_calc = 1'b0;
    case (parity_t'(tx.i_Parity_Mode))
      PAR_ODD:  par_calc = ~(^tx.i_Tx_Byte);
      PAR_EVEN: par_calc = ^tx.i_Tx_Byte;
      PAR_MARK: par_calc = 1'b1;
      default:  par_calc = 1'b0;
    endcase
  end

  // Next-state, counter and line-level decode for the sequencer.
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    state_d   = state_q;
    baud_d    = '0;
    idx_d     = idx_q;
    stop2_d   = stop2_q;
    serial_d  = 1'b1;
    accept    = 1'b0;
    brk_go    = 1'b0;
    frame_end = 1'b0;

    case (state_q)
      S_IDLE: begin
        idx_d   = '0;
        stop2_d = 1'b0;
        // ready_q is low for the single hand-off cycle after a frame or break,
        // which keeps Ready/Done aligned with the end of the last line bit.
        if (ready_q) begin
`ifdef UART_TX_BREAK_EN
          if (i_Break) begin
            brk_go  = 1'b1;
            state_d = S_BREAK;
          end else if (tx.i_Tx_DV) begin
            accept  = 1'b1;
            state_d = S_START;
          end
`else
          if (tx.i_Tx_DV) begin
            accept  = 1'b1;
            state_d = S_START;
          end
`endif
        end
      end

      S_START: begin
        serial_d = 1'b0;
        baud_d   = baud_next;
        if (bit_end) state_d = S_DATA;
      end

      S_DATA: begin
        serial_d = data_q[idx_q];
        baud_d   = baud_next;
        if (bit_end) begin
          if (idx_q == IDX_LAST) begin
            idx_d   = '0;
            state_d = par_en_q ? S_PARITY : S_STOP;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end

      S_PARITY: begin
        serial_d = par_bit_q;
        baud_d   = baud_next;
        if (bit_end) state_d = S_STOP;
      end

      S_STOP: begin
        // Two stop bits form one continuous mark; the counter wraps once
        // inside it and stop2 marks the second half.
        serial_d = 1'b1;
        baud_d   = baud_next;
        if (bit_end) begin
          if (two_stop_q && !stop2_q) begin
            stop2_d = 1'b1;
          end else begin
            stop2_d   = 1'b0;
            frame_end = 1'b1;
            state_d   = S_IDLE;
          end
        end
      end

`ifdef UART_TX_BREAK_EN
      S_BREAK: begin
        serial_d = 1'b0;
        if (!i_Break) state_d = S_BRK_MARK;
      end

      S_BRK_MARK: begin
        serial_d = 1'b1;
        baud_d   = baud_next;
        if (bit_end) state_d = S_IDLE;
      end
`endif

      default: begin
        state_d = S_IDLE;
        idx_d   = '0;
        stop2_d = 1'b0;
      end
    endcase
  end

  // Ready only while genuinely idle and not consuming a request this cycle.
  assign ready_d = (state_q == S_IDLE) && !accept && !brk_go;

  // Sequencer state register.
  always_ff @(posedge i_Clock or negedge i_Rst_n) begin
    // NOTE: state elements use non-blocking assignments so every flop samples
    // the pre-edge values regardless of statement order.
    if (!i_Rst_n) begin
      state_q <= S_IDLE;
      baud_q  <= '0;
      idx_q   <= '0;
      stop2_q <= 1'b0;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      idx_q   <= idx_d;
      stop2_q <= stop2_d;
    end
  end

  // Frame registers: loaded only at acceptance, so input changes mid-frame
  // cannot disturb the character in flight.
  always_ff @(posedge i_Clock or negedge i_Rst_n) begin
    // NOTE: these are a handful of flops, not a RAM, so they take the reset
    // like everything else and never start out as X.
    if (!i_Rst_n) begin
      data_q     <= '0;
      par_en_q   <= 1'b0;
      par_bit_q  <= 1'b0;
      two_stop_q <= 1'b0;
    end else if (accept) begin
      data_q     <= tx.i_Tx_Byte;
      par_en_q   <= (tx.i_Parity_Mode != PAR_NONE);
      par_bit_q  <= par_calc;
      two_stop_q <= tx.i_Two_Stop;
    end
  end

  // Registered output stage, one cycle behind the sequencer; the async reset
  // drives the line high immediately and drops any pending Done.
  always_ff @(posedge i_Clock or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      serial_q    <= 1'b1;
      ready_q     <= 1'b1;
      active_q    <= 1'b0;
      frame_end_q <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      serial_q    <= serial_d;
      ready_q     <= ready_d;
      active_q    <= !ready_d;
      frame_end_q <= frame_end;
      done_q      <= frame_end_q;
    end
  end

  assign tx.o_Tx_Serial = serial_q;
  assign tx.o_Tx_Ready  = ready_q;
  assign tx.o_Tx_Active = active_q;
  assign tx.o_Tx_Done   = done_q;

endmodule

// File: tb/tb_uart_tx_cfg.sv
// tb_uart_tx_cfg: directed bench for uart_tx_cfg. Stimulus pushes the expected
// line pattern of each frame into a scoreboard; a monitor pops an entry on each
// start bit and checks every bit period, Done timing and start-to-start gaps.
module tb_uart_tx_cfg;
  localparam int CPB = 4;

  logic clk = 1'b0;
  logic rst_n;
  int   cyc = 0;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  uart_tx_cfg_if #(.DATA_BITS(8)) if_a ();
  uart_tx_cfg_if #(.DATA_BITS(5)) if_b ();

`ifdef UART_TX_BREAK_EN
  logic brk;
  logic brk_b;
`endif

  uart_tx_cfg #(.CLKS_PER_BIT(CPB), .DATA_BITS(8)) dut_a (
    .i_Clock (clk),
    .i_Rst_n (rst_n),
`ifdef UART_TX_BREAK_EN
    .i_Break (brk),
`endif
    .tx      (if_a)
  );

  uart_tx_cfg #(.CLKS_PER_BIT(CPB), .DATA_BITS(5)) dut_b (
    .i_Clock (clk),
    .i_Rst_n (rst_n),
`ifdef UART_TX_BREAK_EN
    .i_Break (brk_b),
`endif
    .tx      (if_b)
  );

  // Scoreboard entry: line levels in send order, MSB of the nbits field first.
  typedef struct {
    int          id;
    logic [15:0] pat;
    int          nbits;
    int          gap;
  } exp_t;

  exp_t sb[$];

  logic mon_sel;
  logic mon_en;
  logic mon_serial, mon_done, mon_ready;

  always_comb begin
    mon_serial = mon_sel ? if_b.o_Tx_Serial : if_a.o_Tx_Serial;
    mon_done   = mon_sel ? if_b.o_Tx_Done   : if_a.o_Tx_Done;
    mon_ready  = mon_sel ? if_b.o_Tx_Ready  : if_a.o_Tx_Ready;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    check(name, 32'(act), 32'(exp));
  endtask

  function automatic logic cur_ready(input bit sel);
    return sel ? if_b.o_Tx_Ready : if_a.o_Tx_Ready;
  endfunction

  function automatic logic cur_active(input bit sel);
    return sel ? if_b.o_Tx_Active : if_a.o_Tx_Active;
  endfunction

  function automatic logic cur_serial(input bit sel);
    return sel ? if_b.o_Tx_Serial : if_a.o_Tx_Serial;
  endfunction

  task automatic set_in(input bit sel, input logic dv, input logic [8:0] data,
                        input logic [1:0] mode, input logic two);
    if (sel) begin
      if_b.i_Tx_DV       = dv;
      if_b.i_Tx_Byte     = data[4:0];
      if_b.i_Parity_Mode = mode;
      if_b.i_Two_Stop    = two;
    end else begin
      if_a.i_Tx_DV       = dv;
      if_a.i_Tx_Byte     = data[7:0];
      if_a.i_Parity_Mode = mode;
      if_a.i_Two_Stop    = two;
    end
  endtask

  task automatic push_exp(input int id, input logic [15:0] pat, input int nbits, input int gap);
    exp_t e;
    e.id    = id;
    e.pat   = pat;
    e.nbits = nbits;
    e.gap   = gap;
    sb.push_back(e);
  endtask

  // Waits (bounded) at negedges until Ready is seen high.
  task automatic wait_ready(input bit sel, input string name);
    int n = 0;
    while (cur_ready(sel) !== 1'b1 && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (n >= 400) check1($sformatf("%s ready_wait", name), cur_ready(sel), 1'b1);
  endtask

  task automatic wait_idle(input bit sel);
    @(negedge clk);
    wait_ready(sel, "idle");
    repeat (3) @(negedge clk);
  endtask

  // One handshake: DV raised at a negedge, dropped the negedge after acceptance.
  task automatic send(input bit sel, input logic [8:0] data, input logic [1:0] mode,
                      input logic two, input int id, input logic [15:0] pat, input int nbits);
    push_exp(id, pat, nbits, 0);
    @(negedge clk);
    set_in(sel, 1'b1, data, mode, two);
    wait_ready(sel, "send");
    @(negedge clk);
    set_in(sel, 1'b0, data, mode, two);
    check1($sformatf("f%0d ready_low", id), cur_ready(sel), 1'b0);
    check1($sformatf("f%0d active_high", id), cur_active(sel), 1'b1);
    check1($sformatf("f%0d serial_still_high", id), cur_serial(sel), 1'b1);
  endtask

  // Monitor: one scoreboard entry per start bit.
  initial begin : monitor
    exp_t e;
    int   start_cyc;
    int   last_start;
    int   done_seen;
    logic exp_lvl, act_lvl;
    last_start = 0;
    forever begin
      @(negedge clk);
      if (mon_en && mon_serial === 1'b0) begin
        start_cyc = cyc;
        if (sb.size() == 0) begin
          check1("unexpected_frame", 1'b1, 1'b0);
          for (int n = 0; n < 200 && mon_serial !== 1'b1; n++) @(negedge clk);
        end else begin
          e = sb.pop_front();
          if (e.gap != 0)
            check($sformatf("f%0d start_gap", e.id), 32'(start_cyc - last_start), 32'(e.gap));
          last_start = start_cyc;
          done_seen  = 0;
          for (int k = 0; k < e.nbits; k++) begin
            exp_lvl = e.pat[e.nbits-1-k];
            act_lvl = exp_lvl;
            for (int c = 0; c < CPB; c++) begin
              if (k != 0 || c != 0) @(negedge clk);
              if (mon_serial !== exp_lvl) act_lvl = mon_serial;
              if (mon_done === 1'b1) done_seen++;
            end
            check1($sformatf("f%0d bit%0d", e.id, k), act_lvl, exp_lvl);
          end
          @(negedge clk);
          check($sformatf("f%0d early_done", e.id), 32'(done_seen), 32'd0);
          check1($sformatf("f%0d done_pulse", e.id), mon_done, 1'b1);
          check1($sformatf("f%0d ready_at_done", e.id), mon_ready, 1'b1);
          @(negedge clk);
          check1($sformatf("f%0d done_one_cycle", e.id), mon_done, 1'b0);
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: time limit reached, errors=%0d", errors);
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    int dcnt;
    rst_n   = 1'b0;
    mon_en  = 1'b0;
    mon_sel = 1'b0;
    set_in(1'b0, 1'b0, 9'h000, 2'b00, 1'b0);
    set_in(1'b1, 1'b0, 9'h000, 2'b00, 1'b0);
`ifdef UART_TX_BREAK_EN
    brk   = 1'b0;
    brk_b = 1'b0;
`endif

    // Reset values
    repeat (3) @(negedge clk);
    check1("rst a serial", if_a.o_Tx_Serial, 1'b1);
    check1("rst a ready",  if_a.o_Tx_Ready,  1'b1);
    check1("rst a active", if_a.o_Tx_Active, 1'b0);
    check1("rst a done",   if_a.o_Tx_Done,   1'b0);
    check1("rst b serial", if_b.o_Tx_Serial, 1'b1);
    check1("rst b ready",  if_b.o_Tx_Ready,  1'b1);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    mon_en = 1'b1;

    // 8N1 0xA5, with an ignored DV pulse (new byte and config) mid-frame
    send(1'b0, 9'h0A5, 2'b00, 1'b0, 1, 16'b0101001011, 10);
    repeat (10) @(negedge clk);
    set_in(1'b0, 1'b1, 9'h0FF, 2'b11, 1'b1);
    @(negedge clk);
    set_in(1'b0, 1'b0, 9'h0FF, 2'b11, 1'b1);
    wait_idle(1'b0);

    // 0x07 even parity, two stop bits; then odd parity, one stop bit
    send(1'b0, 9'h007, 2'b10, 1'b1, 2, 16'b011100000111, 12);
    wait_idle(1'b0);
    send(1'b0, 9'h007, 2'b01, 1'b0, 3, 16'b01110000001, 11);
    wait_idle(1'b0);

    // DATA_BITS=5: 0x1F mark parity; 0x0A odd parity with two stop bits
    mon_sel = 1'b1;
    repeat (2) @(negedge clk);
    send(1'b1, 9'h01F, 2'b11, 1'b0, 4, 16'b01111111, 8);
    wait_idle(1'b1);
    send(1'b1, 9'h00A, 2'b01, 1'b1, 5, 16'b001010111, 9);
    wait_idle(1'b1);
    mon_sel = 1'b0;
    repeat (2) @(negedge clk);

    // Back-to-back with DV held: 0x55 then 0x0F, start-to-start F+2 = 42
    push_exp(6, 16'b0101010101, 10, 0);
    push_exp(7, 16'b0111100001, 10, 42);
    @(negedge clk);
    set_in(1'b0, 1'b1, 9'h055, 2'b00, 1'b0);
    wait_ready(1'b0, "b2b first");
    @(negedge clk);
    set_in(1'b0, 1'b1, 9'h00F, 2'b00, 1'b0);
    check1("b2b ready_low", if_a.o_Tx_Ready, 1'b0);
    @(negedge clk);
    wait_ready(1'b0, "b2b second");
    @(negedge clk);
    set_in(1'b0, 1'b0, 9'h00F, 2'b00, 1'b0);
    wait_idle(1'b0);

    // Reset asserted mid-DATA (data 0x00 keeps the line low)
    mon_en = 1'b0;
    @(negedge clk);
    set_in(1'b0, 1'b1, 9'h000, 2'b00, 1'b0);
    wait_ready(1'b0, "rst frame");
    @(negedge clk);
    set_in(1'b0, 1'b0, 9'h000, 2'b00, 1'b0);
    repeat (8) @(negedge clk);
    check1("pre_rst serial_low", if_a.o_Tx_Serial, 1'b0);
    #1 rst_n = 1'b0;
    #1;
    check1("async_rst serial", if_a.o_Tx_Serial, 1'b1);
    check1("async_rst ready",  if_a.o_Tx_Ready,  1'b1);
    check1("async_rst active", if_a.o_Tx_Active, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    dcnt = 0;
    for (int n = 0; n < 60; n++) begin
      @(negedge clk);
      if (if_a.o_Tx_Done === 1'b1) dcnt++;
    end
    check("rst no_done", 32'(dcnt), 32'd0);
    check1("rst line_idle", if_a.o_Tx_Serial, 1'b1);

`ifdef UART_TX_BREAK_EN
    // Break for 20 cycles: 20 low line cycles, then 4 high before Ready
    begin
      int lows, highs, bdone, k;
      logic act_mid, rdy_mid;
      lows = 0; highs = 0; bdone = 0; k = 0;
      act_mid = 1'b0; rdy_mid = 1'b1;
      @(negedge clk);
      brk = 1'b1;
      do begin
        @(negedge clk);
        if (if_a.o_Tx_Serial === 1'b0) lows++;
        else if (lows > 0 && if_a.o_Tx_Ready === 1'b0) highs++;
        if (if_a.o_Tx_Done === 1'b1) bdone++;
        if (k == 10) begin
          act_mid = if_a.o_Tx_Active;
          rdy_mid = if_a.o_Tx_Ready;
        end
        if (k == 19) brk = 1'b0;
        k++;
      end while (!(k > 1 && if_a.o_Tx_Ready === 1'b1) && k < 200);
      check("brk low_cycles", 32'(lows), 32'd20);
      check("brk mark_cycles", 32'(highs), 32'd4);
      check("brk no_done", 32'(bdone), 32'd0);
      check1("brk active", act_mid, 1'b1);
      check1("brk ready", rdy_mid, 1'b0);
    end
`endif

    mon_en = 1'b1;
    repeat (5) @(negedge clk);
    check("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
